pipe_if_fetchq: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue. It decouples a synchronous-read instruction memory (1-cycle latency) from decode through a DEPTH-entry {pc, instruction} FIFO. It adds an exception-vector redirect mode, a valid/stall output handshake and flush-on-redirect. It sits between the imem and the IF/ID consumer, replacing the single-register PC stage.

---
 rtl/pipe_if_fetchq_pkg.sv | 15 +
 rtl/pipe_if_fetchq_fifo.sv | 67 ++++++
 rtl/pipe_if_fetchq.sv | 124 ++++++++++++
 tb/tb_pipe_if_fetchq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_if_fetchq_pkg.sv
// pipe_if_fetchq_pkg: shared constants for the fetch stage with prefetch queue.
//   PC_SEL_*            encodings of in_pc_sel
//   DEFAULT_RESET_PC    default fetch PC after reset
//   DEFAULT_EXC_VECTOR  default exception redirect target
package pipe_if_fetchq_pkg;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_J   = 2'b10;
    localparam logic [1:0] PC_SEL_EXC = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/pipe_if_fetchq_fifo.sv
// fetchq_fifo: DEPTH-entry FIFO with synchronous reset and flush.
//   in_clk, in_rst      clock, synchronous active-high reset
//   in_flush            empty the queue at the next edge (same effect as reset)
//   in_push, in_wdata   write an entry at the tail
//   in_pop              drop the head entry (ignored when empty)
//   out_rdata           head entry, combinational read
//   out_empty           no entries held
//   out_count           occupancy, 0..DEPTH
module fetchq_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic                     in_flush,
    input  logic                     in_push,
    input  logic [WIDTH-1:0]         in_wdata,
    input  logic                     in_pop,
    output logic [WIDTH-1:0]         out_rdata,
    output logic                     out_empty,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = in_pop && (r_count != '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_push = in_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge in_clk) begin
        if (in_rst || in_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_do_pop) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: the head is only consumed when out_empty is 0.
    always_ff @(posedge in_clk) begin
        if (w_do_push && !in_rst && !in_flush) begin
            r_mem[r_tail] <= in_wdata;
        end
    end

    assign out_rdata = r_mem[r_head];
    assign out_empty = (r_count == '0);
    assign out_count = r_count;

endmodule

// File: rtl/pipe_if_fetchq.sv
// pipe_if_fetchq: instruction fetch stage with a prefetch queue between a
// 1-cycle-latency instruction memory and the decode stage.
//   in_clk, in_rst                 clock, synchronous active-high reset
//   in_stall                       consumer hold, head not popped while 1
//   in_pc_sel                      00 seq, 01 branch, 10 jump, 11 exception
//   in_pc_baddr, in_pc_jaddr       redirect targets (low two bits ignored)
//   out_imem_en, out_imem_addr     imem read request and word address
//   in_imem_rdata                  imem data, valid the cycle after a request
//   out_valid, out_pc, out_npc,
//   out_instruction                head of queue (all zero when !out_valid)
//   out_count                      queue occupancy
module pipe_if_fetchq
    import pipe_if_fetchq_pkg::*;
#(
    parameter int unsigned    PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEFAULT_RESET_PC),
    parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(DEFAULT_EXC_VECTOR),
    parameter int unsigned    DEPTH      = 4,
    parameter int unsigned    IMEM_AW    = 10
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_stall,
    input  logic [1:0]             in_pc_sel,
    input  logic [PC_W-1:0]        in_pc_baddr,
    input  logic [PC_W-1:0]        in_pc_jaddr,
    output logic                   out_imem_en,
    output logic [IMEM_AW-1:0]     out_imem_addr,
    input  logic [31:0]            in_imem_rdata,
    output logic                   out_valid,
    output logic [PC_W-1:0]        out_pc,
    output logic [PC_W-1:0]        out_npc,
    output logic [31:0]            out_instruction,
    output logic [$clog2(DEPTH):0] out_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = PC_W + 32;

    logic [PC_W-1:0]  r_fpc;
    logic [PC_W-1:0]  r_ipc;
    logic             r_inflight;

    logic             w_redirect;
    logic [PC_W-1:0]  w_target_raw;
    logic [PC_W-1:0]  w_target;
    logic [CNT_W:0]   w_occupancy;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_valid;
    logic [CNT_W-1:0] w_count;
    logic [ENT_W-1:0] w_head;
    logic [PC_W-1:0]  w_head_pc;
    logic [31:0]      w_head_instr;

    assign w_redirect = (in_pc_sel != PC_SEL_SEQ);

    always_comb begin
        w_target_raw = r_fpc;
        unique case (in_pc_sel)
            PC_SEL_BR:  w_target_raw = in_pc_baddr;
            PC_SEL_J:   w_target_raw = in_pc_jaddr;
            PC_SEL_EXC: w_target_raw = EXC_VECTOR;
            default:    w_target_raw = r_fpc;
        endcase
    end

    assign w_target = w_target_raw & ~PC_W'(3);

    // Conservative: a pop in this same cycle does not free a slot until the next one.
    assign w_occupancy = {1'b0, w_count} + (CNT_W + 1)'(r_inflight);
    assign w_issue     = !in_rst && !w_redirect && (w_occupancy < (CNT_W + 1)'(DEPTH));

    assign w_push = r_inflight && !w_redirect;
    assign w_valid = !w_empty;
    assign w_pop  = w_valid && !in_stall && !w_redirect;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_fpc      <= RESET_PC;
            r_ipc      <= '0;
            r_inflight <= 1'b0;
        end else if (w_redirect) begin
            // The response to any request in flight is dropped with the queue.
            r_fpc      <= w_target;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_ipc <= r_fpc;
                r_fpc <= r_fpc + PC_W'(4);
            end
        end
    end

    fetchq_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_flush  (w_redirect),
        .in_push   (w_push),
        .in_wdata  ({r_ipc, in_imem_rdata}),
        .in_pop    (w_pop),
        .out_rdata (w_head),
        .out_empty (w_empty),
        .out_count (w_count)
    );

    assign w_head_pc    = w_head[ENT_W-1:32];
    assign w_head_instr = w_head[31:0];

    assign out_imem_en     = w_issue;
    assign out_imem_addr   = r_fpc[IMEM_AW+1:2];
    assign out_valid       = w_valid;
    assign out_pc          = w_valid ? w_head_pc : '0;
    assign out_npc         = w_valid ? (w_head_pc + PC_W'(4)) : '0;
    assign out_instruction = w_valid ? w_head_instr : '0;
    assign out_count       = w_count;

endmodule

// File: tb/tb_pipe_if_fetchq.sv
// Bench for pipe_if_fetchq: directed table, randomized run against a queue-level
// reference model, and a PC wrap-around check on a second instance.
module tb_pipe_if_fetchq;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [31:0] baddr;
    logic [31:0] jaddr;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
    logic [2:0]  count;

    logic        rst2;
    logic        imem_en2;
    logic [9:0]  imem_addr2;
    logic [31:0] imem_rdata2;
    logic        valid2;
    logic [31:0] pc2;
    logic [31:0] npc2;
    logic [31:0] instr2;
    logic [2:0]  count2;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_if_fetchq u_dut (
        .in_clk          (clk),
        .in_rst          (rst),
        .in_stall        (stall),
        .in_pc_sel       (pc_sel),
        .in_pc_baddr     (baddr),
        .in_pc_jaddr     (jaddr),
        .out_imem_en     (imem_en),
        .out_imem_addr   (imem_addr),
        .in_imem_rdata   (imem_rdata),
        .out_valid       (valid),
        .out_pc          (pc),
        .out_npc         (npc),
        .out_instruction (instr),
        .out_count       (count)
    );

    pipe_if_fetchq #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_dut_wrap (
        .in_clk          (clk),
        .in_rst          (rst2),
        .in_stall        (1'b0),
        .in_pc_sel       (2'b00),
        .in_pc_baddr     (32'h0),
        .in_pc_jaddr     (32'h0),
        .out_imem_en     (imem_en2),
        .out_imem_addr   (imem_addr2),
        .in_imem_rdata   (imem_rdata2),
        .out_valid       (valid2),
        .out_pc          (pc2),
        .out_npc         (npc2),
        .out_instruction (instr2),
        .out_count       (count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: word k holds 0x1000_0000 + k, one cycle read latency.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'h1000_0000 + 32'(imem_addr);
        if (imem_en2) imem_rdata2 <= 32'h1000_0000 + 32'(imem_addr2);
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h1000_0000 + {22'b0, a[11:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the queue holds fetched PCs; at most one request in flight.
    logic [31:0] m_q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_ipc;
    bit          m_infl;
    bit          m_known = 0;

    function automatic bit model_issue();
        return !rst && (pc_sel == 2'b00) && ((m_q.size() + int'(m_infl)) < 4);
    endfunction

    task automatic model_check();
        logic [31:0] e_pc;
        bit          e_valid;
        if (!m_known) return;
        e_valid = (m_q.size() != 0);
        e_pc    = e_valid ? m_q[0] : 32'h0;
        chk("model_valid", 32'(valid), 32'(e_valid));
        chk("model_pc", pc, e_pc);
        chk("model_npc", npc, e_valid ? e_pc + 32'd4 : 32'h0);
        chk("model_instr", instr, e_valid ? word_of(e_pc) : 32'h0);
        chk("model_count", 32'(count), 32'(m_q.size()));
        chk("model_imem_en", 32'(imem_en), 32'(model_issue()));
        if (model_issue()) chk("model_imem_addr", 32'(imem_addr), {22'b0, m_fpc[11:2]});
    endtask

    task automatic model_update();
        bit en;
        logic [31:0] tgt;
        en = model_issue();
        if (rst) begin
            m_q.delete();
            m_infl  = 0;
            m_fpc   = 32'h0;
            m_known = 1;
        end else if (m_known) begin
            if (pc_sel != 2'b00) begin
                tgt = (pc_sel == 2'b01) ? baddr : (pc_sel == 2'b10) ? jaddr : 32'h80;
                m_q.delete();
                m_infl = 0;
                m_fpc  = tgt & ~32'h3;
            end else begin
                if (m_q.size() != 0 && !stall) void'(m_q.pop_front());
                if (m_infl) m_q.push_back(m_ipc);
                m_infl = en;
                if (en) begin
                    m_ipc = m_fpc;
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
    endtask

    task automatic do_cycle(input logic r, input logic s, input logic [1:0] sel,
                            input logic [31:0] ba, input logic [31:0] ja);
        @(negedge clk);
        rst    = r;
        stall  = s;
        pc_sel = sel;
        baddr  = ba;
        jaddr  = ja;
        #1;
        model_check();
        model_update();
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic [1:0]  sel;
        logic [31:0] ba;
        logic [31:0] ja;
        logic        chk;
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        en;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic [1:0] sel,
                       input logic [31:0] ba, input logic [31:0] ja, input logic c,
                       input logic v, input logic [31:0] p, input logic [2:0] n,
                       input logic e);
        vec_t x;
        x.rst = r; x.stall = s; x.sel = sel; x.ba = ba; x.ja = ja;
        x.chk = c; x.valid = v; x.pc = p; x.cnt = n; x.en = e;
        tbl.push_back(x);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pc_sel = 2'b00; baddr = '0; jaddr = '0; rst2 = 1'b1;

        //  rst stall sel  baddr   jaddr   chk valid pc      cnt en
        add(1, 0, 2'd0, 32'h0,  32'h0,   0, 0, 32'h0,   0, 0);
        add(1, 0, 2'd0, 32'h0,  32'h0,   1, 0, 32'h0,   0, 0);
        add(0, 0, 2'd0, 32'h0,  32'h0,   1, 0, 32'h0,   0, 1);
        add(0, 0, 2'd0, 32'h0,  32'h0,   1, 0, 32'h0,   0, 1);
        add(0, 0, 2'd0, 32'h0,  32'h0,   1, 1, 32'h0,   1, 1);
        add(0, 1, 2'd0, 32'h0,  32'h0,   1, 1, 32'h4,   1, 1);
        add(0, 1, 2'd0, 32'h0,  32'h0,   1, 1, 32'h4,   2, 1);
        add(0, 1, 2'd0, 32'h0,  32'h0,   1, 1, 32'h4,   3, 0);
        add(0, 1, 2'd0, 32'h0,  32'h0,   1, 1, 32'h4,   4, 0);
        add(0, 1, 2'd0, 32'h0,  32'h0,   1, 1, 32'h4,   4, 0);
        add(0, 0, 2'd0, 32'h0,  32'h0,   1, 1, 32'h4,   4, 0);
        add(0, 0, 2'd0, 32'h0,  32'h0,   1, 1, 32'h8,   3, 1);
        add(0, 0, 2'd0, 32'h0,  32'h0,   1, 1, 32'hC,   2, 1);
        add(0, 0, 2'd1, 32'h40, 32'h0,   1, 1, 32'h10,  2, 0);
        add(0, 0, 2'd0, 32'h0,  32'h0,   1, 0, 32'h0,   0, 1);
        add(0, 0, 2'd0, 32'h0,  32'h0,   1, 0, 32'h0,   0, 1);
        add(0, 1, 2'd3, 32'h0,  32'h0,   1, 1, 32'h40,  1, 0);
        add(0, 1, 2'd0, 32'h0,  32'h0,   1, 0, 32'h0,   0, 1);
        add(0, 1, 2'd0, 32'h0,  32'h0,   1, 0, 32'h0,   0, 1);
        add(0, 0, 2'd2, 32'h0,  32'h103, 1, 1, 32'h80,  1, 0);
        add(0, 0, 2'd0, 32'h0,  32'h0,   1, 0, 32'h0,   0, 1);
        add(0, 0, 2'd0, 32'h0,  32'h0,   1, 0, 32'h0,   0, 1);
        add(0, 0, 2'd0, 32'h0,  32'h0,   1, 1, 32'h100, 1, 1);
        add(0, 1, 2'd0, 32'h0,  32'h0,   1, 1, 32'h104, 1, 1);
        add(0, 1, 2'd0, 32'h0,  32'h0,   1, 1, 32'h104, 2, 1);
        add(0, 1, 2'd0, 32'h0,  32'h0,   1, 1, 32'h104, 3, 0);
        add(1, 1, 2'd0, 32'h0,  32'h0,   1, 1, 32'h104, 4, 0);
        add(0, 0, 2'd0, 32'h0,  32'h0,   1, 0, 32'h0,   0, 1);
        add(0, 0, 2'd0, 32'h0,  32'h0,   1, 0, 32'h0,   0, 1);
        add(0, 0, 2'd0, 32'h0,  32'h0,   1, 1, 32'h0,   1, 1);

        foreach (tbl[i]) begin
            do_cycle(tbl[i].rst, tbl[i].stall, tbl[i].sel, tbl[i].ba, tbl[i].ja);
            if (tbl[i].chk) begin
                chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
                chk($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
                chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
                chk($sformatf("vec%0d_imem_en", i), 32'(imem_en), 32'(tbl[i].en));
            end
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic        r;
            logic        s;
            logic [1:0]  sel;
            logic [31:0] ba;
            logic [31:0] ja;
            r   = ($urandom_range(63) == 0);
            s   = ($urandom_range(9) < 4);
            sel = ($urandom_range(11) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            ba  = $urandom_range(1) ? $urandom : 32'($urandom_range(4095));
            ja  = $urandom_range(1) ? $urandom : 32'($urandom_range(4095));
            do_cycle(r, s, sel, ba, ja);
        end

        // PC wrap-around on the second instance.
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("wrap_valid_fill0", 32'(valid2), 32'h0);
        @(negedge clk);
        #1;
        chk("wrap_valid_fill1", 32'(valid2), 32'h0);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] e_pc;
            e_pc = 32'hFFFF_FFF8 + 32'(4 * k);
            @(negedge clk);
            #1;
            chk($sformatf("wrap%0d_valid", k), 32'(valid2), 32'h1);
            chk($sformatf("wrap%0d_pc", k), pc2, e_pc);
            chk($sformatf("wrap%0d_npc", k), npc2, e_pc + 32'd4);
            chk($sformatf("wrap%0d_instr", k), instr2, word_of(e_pc));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
